// File: rtl/alu_pipe_muldiv_pkg.sv
// Shared opcode header for the pipelined ALU: opcode encodings, i_extra bit
// meanings and the multi-cycle FSM state encodings.
package alu_pipe_muldiv_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_SHIFT = 4'h4;
    localparam logic [3:0] OP_MOVE  = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_JUMP  = 4'h8;
    localparam logic [3:0] OP_LOADC = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;
    localparam logic [3:0] OP_DIV   = 4'hB;

    // Bit positions within i_extra
    localparam int unsigned EXTRA_CONST      = 0;
    localparam int unsigned SHIFT_LEFT       = 0;
    localparam int unsigned SHIFT_FROM_CONST = 1;
    localparam int unsigned SEL_HIGH_REM     = 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MUL_RUN = 2'd1;
    localparam logic [1:0] ST_DIV_RUN = 2'd2;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One iteration per cycle, WIDTH iterations; done flags the final iteration.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             divisor_zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic             busy;
    logic             div_mode;
    logic [CW-1:0]    step;
    logic [WIDTH-1:0] acc;    // MUL: product high half, DIV: partial remainder
    logic [WIDTH-1:0] shreg;  // MUL: multiplier -> product low, DIV: dividend -> quotient
    logic [WIDTH-1:0] opnd;   // multiplicand or divisor

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    always_comb begin
        mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
        div_shift = {acc, shreg[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (div_mode) begin
            nxt_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            nxt_lo = {shreg[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], shreg[WIDTH-1:1]};
        end
    end

    // Results are presented combinationally during the last iteration so the
    // owner can register them on the same edge the engine finishes.
    assign done         = busy && (step == LAST_STEP);
    assign res_hi       = nxt_hi;
    assign res_lo       = nxt_lo;
    assign divisor_zero = (opnd == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            div_mode <= 1'b0;
            step     <= '0;
            acc      <= '0;
            shreg    <= '0;
            opnd     <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            div_mode <= is_div;
            step     <= '0;
            acc      <= '0;
            shreg    <= op_a;
            opnd     <= op_b;
        end else if (busy) begin
            acc   <= nxt_hi;
            shreg <= nxt_lo;
            step  <= step + CW'(1);
            if (step == LAST_STEP) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe_muldiv.sv
// Registered ALU with valid/ready handshake, status flags and iterative
// unsigned MUL/DIV; single-cycle ops issue back-to-back.
module alu_pipe_muldiv
    import alu_pipe_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned CONST_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [3:0]             i_opcode,
    input  logic [1:0]             i_extra,
    input  logic [WIDTH-1:0]       i_data1,
    input  logic [WIDTH-1:0]       i_data2,
    input  logic [CONST_WIDTH-1:0] i_const,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_carry,
    output logic                   o_zero,
    output logic                   o_neg,
    output logic                   o_div0
);

    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    logic [1:0]       state;
    logic             sel_high;
    logic             accept;
    logic [WIDTH-1:0] const_ext;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] shamt;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shl_wide;
    logic [WIDTH:0]   shr_wide;
    logic [WIDTH-1:0] sc_data;
    logic             sc_carry;

    logic             eng_start;
    logic             eng_done;
    logic             eng_div0;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             wr_carry;
    logic             wr_div0_en;

    assign o_ready   = (state == ST_IDLE);
    assign accept    = i_valid && o_ready;
    assign const_ext = WIDTH'(i_const);
    assign op2       = i_extra[EXTRA_CONST] ? const_ext : i_data2;
    assign shamt     = i_extra[SHIFT_FROM_CONST] ? const_ext : i_data2;
    assign eng_start = accept && is_multicycle(i_opcode);

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk         (i_clk),
        .reset       (i_reset),
        .start       (eng_start),
        .is_div      (i_opcode == OP_DIV),
        .op_a        (i_data1),
        .op_b        (op2),
        .done        (eng_done),
        .res_hi      (eng_hi),
        .res_lo      (eng_lo),
        .divisor_zero(eng_div0)
    );

    // One extra guard bit on each shifter holds the last bit shifted out.
    always_comb begin
        add_sum  = {1'b0, i_data1} + {1'b0, op2};
        shl_wide = {1'b0, i_data1} << shamt;
        shr_wide = {i_data1, 1'b0} >> shamt;
        sc_data  = '0;
        sc_carry = 1'b0;
        case (i_opcode)
            OP_ADD: {sc_carry, sc_data} = add_sum;
            OP_SUB: begin
                sc_data  = i_data1 - op2;
                sc_carry = i_data1 < op2;
            end
            OP_AND:  sc_data = i_data1 & op2;
            OP_OR:   sc_data = i_data1 | op2;
            OP_MOVE: sc_data = i_data1;
            OP_SHIFT: begin
                if (shamt <= SHIFT_LIMIT) begin
                    if (i_extra[SHIFT_LEFT]) begin
                        sc_data  = shl_wide[WIDTH-1:0];
                        sc_carry = shl_wide[WIDTH];
                    end else begin
                        sc_data  = shr_wide[WIDTH:1];
                        sc_carry = shr_wide[0];
                    end
                end
            end
            OP_LOAD, OP_STORE, OP_JUMP, OP_LOADC: begin
                sc_data  = '0;
                sc_carry = 1'b0;
            end
            default: begin
                sc_data  = '0;
                sc_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_en      = 1'b0;
        wr_data    = sc_data;
        wr_carry   = sc_carry;
        wr_div0_en = 1'b0;
        case (state)
            ST_IDLE: wr_en = accept && !is_multicycle(i_opcode);
            ST_MUL_RUN: begin
                wr_en    = eng_done;
                wr_data  = sel_high ? eng_hi : eng_lo;
                wr_carry = !sel_high && (eng_hi != '0);
            end
            ST_DIV_RUN: begin
                wr_en      = eng_done;
                wr_data    = sel_high ? eng_hi : eng_lo;
                wr_carry   = 1'b0;
                wr_div0_en = eng_done;
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            sel_high <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_carry  <= 1'b0;
            o_zero   <= 1'b0;
            o_neg    <= 1'b0;
            o_div0   <= 1'b0;
        end else begin
            o_valid <= wr_en;
            if (wr_en) begin
                o_data  <= wr_data;
                o_carry <= wr_carry;
                o_zero  <= (wr_data == '0);
                o_neg   <= wr_data[WIDTH-1];
            end
            if (wr_div0_en) begin
                o_div0 <= eng_div0;
            end
            case (state)
                ST_IDLE: begin
                    if (eng_start) begin
                        state    <= (i_opcode == OP_DIV) ? ST_DIV_RUN : ST_MUL_RUN;
                        sel_high <= i_extra[SEL_HIGH_REM];
                    end
                end
                ST_MUL_RUN, ST_DIV_RUN: begin
                    if (eng_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_pipe_muldiv.md
Name: alu_pipe_muldiv

Overview:
Parametrised successor to the CPU's combinational ALU. Adds registered outputs, a valid/ready handshake, status flags (carry, zero, negative, divide-by-zero), and iterative unsigned multiply and divide.
- Single-cycle ops (ADD, SUB, AND, OR, SHIFT, MOVE) complete 1 cycle after acceptance.
- MUL and DIV run WIDTH iterations in an internal engine.
- Sits between the register-file read stage and writeback; the control unit stalls on o_ready.

Parameters:
WIDTH, 16, datapath width in bits (>= 4)
CONST_WIDTH, 8, immediate width; zero-extended to WIDTH (CONST_WIDTH <= WIDTH)

Ports:
i_clk  input  1  system clock; one clock, all logic on rising edge
i_reset  input  1  reset is synchronous and active-high
i_valid  input  1  operation present on inputs this cycle
o_ready  output  1  block can accept an operation this cycle
i_opcode  input  4  operation select; encodings from the shared opcode header
i_extra  input  2  operation modifier (see Behaviour)
i_data1  input  WIDTH  operand A (Ra)
i_data2  input  WIDTH  operand B (Rb)
i_const  input  CONST_WIDTH  immediate
o_valid  output  1  one-cycle pulse: o_data and flags are valid
o_data  output  WIDTH  result, held until the next o_valid
o_carry  output  1  carry / borrow / overflow flag
o_zero  output  1  o_data == 0
o_neg  output  1  o_data[WIDTH-1]
o_div0  output  1  last DIV had a zero divisor

Behaviour:
Handshake and reset:
- Accept when i_valid && o_ready at a rising edge.
- o_ready = (state == IDLE); combinational from the state register.
- Inputs are sampled only at acceptance; they may change afterwards.
- Reset: state <= IDLE; o_valid, o_data, o_carry, o_zero, o_neg, o_div0 <= 0; any MUL/DIV in progress is abandoned with no o_valid.
- i_valid is ignored while i_reset is high.

Operand selection:
- op2 = i_extra[0] ? zero-extended i_const : i_data2.
- This applies to ADD, SUB, AND, OR, MUL and DIV.

Single-cycle ops (state stays IDLE; o_valid next cycle; back-to-back acceptance every cycle allowed):
- ADD: {carry, data} = A + op2.
- SUB: data = A - op2; carry = borrow, i.e. A < op2 unsigned.
- AND, OR: carry = 0.
- MOVE: data = A; carry = 0.
- SHIFT:
  - i_extra[0]: 0 = logical right, 1 = left.
  - i_extra[1]: 0 = amount from i_data2, 1 = amount from i_const.
  - Full-width amount; amount >= WIDTH gives 0.
  - carry = last bit shifted out (0 if amount = 0; 0 if amount > WIDTH).
- Any other opcode (LOAD, STORE, JUMP, LOADC, undefined): data = 0, carry = 0, o_valid still pulses.
- o_zero and o_neg always derive from the new o_data.
- o_div0 is updated only by DIV and holds its value otherwise.

MUL / DIV state machine: IDLE -> MUL_RUN | DIV_RUN -> IDLE
- A step counter counts 0..WIDTH-1; one engine iteration per cycle.
- On the last iteration: state -> IDLE, o_valid = 1 in the next cycle.
- Latency is exactly WIDTH+1 cycles, acceptance to o_valid. o_ready is low for WIDTH cycles.
- A new op may be accepted in the same cycle o_valid pulses.
- MUL: unsigned shift-add, 2*WIDTH product.
  - i_extra[1] = 0 returns the low half, with carry = (high half != 0).
  - i_extra[1] = 1 returns the high half, with carry = 0.
- DIV: unsigned restoring division. i_extra[1] = 0 returns the quotient, 1 returns the remainder; carry = 0.
- Divisor = 0: quotient = all ones, remainder = A, o_div0 = 1. Otherwise o_div0 = 0. Latency is unchanged.

Decomposition:
- Shared header (extends the existing opcode header):
  - opcode localparams, with MUL and DIV assigned to two formerly-undefined encodings;
  - i_extra bit-meaning localparams (EXTRA_CONST, SHIFT_LEFT, SHIFT_FROM_CONST, SEL_HIGH_REM);
  - FSM state encodings.
- Sub-module alu_muldiv_iter:
  - holds the accumulator/remainder, the shifted operand and the step counter;
  - start/done handshake;
  - parametrised by WIDTH.
- Top level owns operand select, single-cycle ops, output registers and flags.

Test Plan (WIDTH=16, CONST_WIDTH=8):
- ADD 0xFFFF + const 0x01 (extra=01) -> 1 cycle later o_valid, data 0x0000, carry 1, zero 1; SUB 0x0003 - Rb 0x0005 -> data 0xFFFE, carry 1, neg 1.
- SHIFT left, const 4, A 0x8421 -> data 0x4210, carry 0. SHIFT right, Rb 16, A 0xFFFF -> data 0x0000, carry 1. SHIFT right, Rb 17 -> data 0, carry 0.
- MUL 0x1234 × 0x0100, low half -> o_ready low 16 cycles, o_valid at cycle 17 with data 0x3400, carry 1. Same operands, high half -> data 0x0012.
- DIV 100 / const 7: quotient 14; with extra[1]=1 the remainder is 2. DIV 0x00AB / Rb 0 -> quotient 0xFFFF, div0 1; a following ADD leaves div0 at 1.
- Back-to-back ADDs on consecutive cycles -> o_valid on consecutive cycles, o_ready never drops. ADD accepted in the same cycle a DIV completes -> ADD result 1 cycle after the DIV result.
- Reset asserted at MUL step 8 -> no o_valid, all outputs 0, o_ready 1 on the next cycle. A subsequent MUL 3 × 5 -> 15.
